irst_sched: RTL and testbench
=============================

# irst_sched

Session scheduler and configuration owner for the instruction-fetch runtime self-test (IRST) of mips_16. It holds the software-visible test configuration and drives the 16-bit `irst_reg_data` word into IF_stage. It triggers test sessions on software command or on a periodic timer, drains the pipeline before each session and waits for `irst_done`. It then releases IF_stage back to functional fetch and records session status.

## Interface
Parameters:
- `PERIOD_W`, 16: width of the auto-trigger period counter.
- `WDOG_W`, 12: width of the watchdog counter (used only with `IRST_WDOG_EN`).
- `WDOG_LIMIT`, 12'hFFF: watchdog expiry value, in cycles of RUN.

Ports:
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `cfg_wr_en`, in, 1: one-cycle configuration write strobe.
- `cfg_addr`, in, 2: register select. 0 = CTRL, 1 = THRESH, 2 = ROUNDS, 3 = PERIOD.
- `cfg_wdata`, in, 16: write data.
- `pipe_idle`, in, 1: the pipeline holds no in-flight instruction.
- `irst_done`, in, 1: IF_stage has finished its session.
- `irst_reg_data`, out, 16: drives IF_stage. Bit 15 = session request, [14:8] = PC threshold, [7:6] = 0, [5:0] = round count.
- `drain_req`, out, 1: asks the pipeline to stop fetching and drain.
- `busy`, out, 1: the state is not IDLE.
- `session_cnt`, out, 8: number of completed sessions. Saturates at 255.
- `timeout_err`, out, 1: sticky watchdog flag. Cleared by a CTRL write with bit 3 set.

## Operation
Registers:
- CTRL bit 0 = `en`.
- CTRL bit 1 = `auto`.
- CTRL bit 2 = `start`. Self-clearing one-shot, never stored.
- CTRL bit 3 = `clr_err`. Self-clearing.
- THRESH[6:0], ROUNDS[5:0], PERIOD[PERIOD_W-1:0]. Unused write bits are ignored.

FSM states:
- IDLE:
  - Go to DRAIN on `en && start`.
  - Go to WAIT on `en && auto`. This load sets `per_cnt = PERIOD`.
- WAIT:
  - `per_cnt` decrements each cycle.
  - Go to DRAIN when `per_cnt == 0` or on `start`.
  - Return to IDLE if `en` or `auto` is cleared.
- DRAIN:
  - `drain_req = 1`.
  - When `pipe_idle = 1`, capture THRESH and ROUNDS into shadow registers and go to RUN.
- RUN:
  - `irst_reg_data = {1'b1, thr_sh, 2'b00, rnd_sh}`.
  - On `irst_done = 1`, go to RELEASE and increment `session_cnt`.
- RELEASE:
  - Bit 15 = 0; [14:0] keep the shadow values.
  - When `irst_done = 0`, go to WAIT if `en && auto` (reloading `per_cnt`), else go to IDLE.

Output values:
- `irst_reg_data` = 16'h0 in IDLE, WAIT and DRAIN.
- `busy` = 1 in every state except IDLE.

Rules:
- Writes to THRESH and ROUNDS take effect at the next DRAIN→RUN capture. They never change the word mid-session.
- Clearing `en` mid-session:
  - In DRAIN or WAIT, go to IDLE next cycle.
  - In RUN, go to RELEASE. The abort does not increment `session_cnt`.
- Same-cycle `start` and `en = 0` write: disable wins.
- PERIOD = 0 with `auto`: sessions run back-to-back, with one WAIT cycle between them.
- ROUNDS = 0 is legal. IF_stage finishes after one threshold crossing.
- `start` while `busy` and not in WAIT: ignored.

## Timing
- Configuration writes are visible on the cycle after `cfg_wr_en`.
- `start` in IDLE: DRAIN on cycle +1.
- With `pipe_idle` high, bit 15 rises on cycle +2.
- `irst_done` high: bit 15 falls on the next cycle.
- All outputs are registered.
- Reset values: every output is 0, all registers are 0, state = IDLE.
- `rst` mid-session returns to IDLE and drops bit 15 on the next edge. IF_stage is reset from the same `rst`.

## Configuration
`IRST_WDOG_EN`:
- Defined:
  - A `WDOG_W`-bit counter clears on RUN entry and increments in RUN.
  - When it reaches `WDOG_LIMIT`, set `timeout_err` and go to RELEASE. `session_cnt` does not increment.
  - RELEASE also exits when the counter reaches `WDOG_LIMIT` a second time, even if `irst_done` never falls.
- Undefined:
  - There is no counter and `timeout_err` is tied to 0.
  - RUN waits indefinitely for `irst_done`.

## Structure
- Shared package `mips_16_defs.v`:
  - Register address constants `IRST_CTRL`, `IRST_THRESH`, `IRST_ROUNDS`, `IRST_PERIOD`.
  - CTRL bit positions.
  - `irst_reg_data` field positions (bit 15, [14:8], [5:0]).
- Sub-module `irst_cfg_regs`: register file plus the start and clear one-shots. The FSM stays in `irst_sched`.

## Test plan
- THRESH = 7'h20, ROUNDS = 3, write CTRL = 0x5 (`en` + `start`), `pipe_idle` = 1 → `irst_reg_data` = 16'hA003 on cycle +2; drive `irst_done` → word returns to 16'h2003, then 0 once IDLE is reached; `session_cnt` = 1.
- `auto` with PERIOD = 10 → sessions start 11 cycles after each RELEASE exit; `per_cnt` reload checked; PERIOD = 0 gives back-to-back sessions.
- `pipe_idle` held low for 50 cycles → `drain_req` stays 1 and bit 15 stays 0 throughout; RUN follows 1 cycle after `pipe_idle` rises.
- Write THRESH = 7'h7F during RUN → `irst_reg_data[14:8]` is unchanged until the next session.
- Write CTRL `en` = 0 during RUN → bit 15 drops on the next cycle and `session_cnt` is unchanged.
- With `IRST_WDOG_EN`, never assert `irst_done` → `timeout_err` = 1 after `WDOG_LIMIT` cycles; writing CTRL bit 3 clears it.

Source files
------------

// File: rtl/irst_sched_pkg.sv
// rtl/irst_sched_pkg.sv - shared IRST register map, field positions and FSM state type
package irst_sched_pkg;

    localparam logic [1:0] IRST_CTRL   = 2'd0;
    localparam logic [1:0] IRST_THRESH = 2'd1;
    localparam logic [1:0] IRST_ROUNDS = 2'd2;
    localparam logic [1:0] IRST_PERIOD = 2'd3;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_AUTO    = 1;
    localparam int CTRL_START   = 2;
    localparam int CTRL_CLR_ERR = 3;

    localparam int REQ_BIT = 15;
    localparam int THR_MSB = 14;
    localparam int THR_LSB = 8;
    localparam int RND_MSB = 5;
    localparam int RND_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DRAIN,
        ST_RUN,
        ST_RELEASE
    } state_t;

    function automatic logic [15:0] make_word(input logic req, input logic [6:0] thr,
                                              input logic [5:0] rnd);
        logic [15:0] w;
        w = '0;
        w[REQ_BIT] = req;
        w[THR_MSB:THR_LSB] = thr;
        w[RND_MSB:RND_LSB] = rnd;
        return w;
    endfunction

endpackage

// File: rtl/irst_cfg_regs.sv
// rtl/irst_cfg_regs.sv - IRST configuration registers with start/clear one-shots
module irst_cfg_regs
    import irst_sched_pkg::*;
#(
    parameter int PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_wr_en,
    input  logic [1:0]          cfg_addr,
    input  logic [15:0]         cfg_wdata,
    output logic                en,
    output logic                auto_mode,
    output logic                start,
    output logic                clr_err,
    output logic [6:0]          thresh,
    output logic [5:0]          rounds,
    output logic [PERIOD_W-1:0] period
);

    logic en_q;
    logic auto_q;
    logic ctrl_wr;

    assign ctrl_wr = cfg_wr_en && (cfg_addr == IRST_CTRL);

    // A CTRL write steers the scheduler in its own cycle, so a same-cycle
    // start with en=0 is already seen as disabled.
    assign en        = ctrl_wr ? cfg_wdata[CTRL_EN]   : en_q;
    assign auto_mode = ctrl_wr ? cfg_wdata[CTRL_AUTO] : auto_q;
    assign start     = ctrl_wr && cfg_wdata[CTRL_START];
    assign clr_err   = ctrl_wr && cfg_wdata[CTRL_CLR_ERR];

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q   <= 1'b0;
            auto_q <= 1'b0;
            thresh <= '0;
            rounds <= '0;
            period <= '0;
        end else if (cfg_wr_en) begin
            case (cfg_addr)
                IRST_CTRL: begin
                    en_q   <= cfg_wdata[CTRL_EN];
                    auto_q <= cfg_wdata[CTRL_AUTO];
                end
                IRST_THRESH: thresh <= cfg_wdata[6:0];
                IRST_ROUNDS: rounds <= cfg_wdata[5:0];
                default:     period <= PERIOD_W'(cfg_wdata);
            endcase
        end
    end

endmodule

// File: rtl/irst_sched.sv
// rtl/irst_sched.sv - IRST session scheduler; IRST_WDOG_EN adds the RUN/RELEASE watchdog
module irst_sched
    import irst_sched_pkg::*;
#(
    parameter int                PERIOD_W   = 16,
    parameter int                WDOG_W     = 12,
    parameter logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(12'hFFF)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_wr_en,
    input  logic [1:0]  cfg_addr,
    input  logic [15:0] cfg_wdata,
    input  logic        pipe_idle,
    input  logic        irst_done,
    output logic [15:0] irst_reg_data,
    output logic        drain_req,
    output logic        busy,
    output logic [7:0]  session_cnt,
    output logic        timeout_err
);

    logic                en, auto_mode, start, clr_err;
    logic [6:0]          thresh, thr_sh, thr_n;
    logic [5:0]          rounds, rnd_sh, rnd_n;
    logic [PERIOD_W-1:0] period, per_cnt, per_cnt_n;
    state_t              state, state_n;
    logic                capture, done_inc, wdog_hit, wdog_rel;
    logic [15:0]         word_n;

    irst_cfg_regs #(.PERIOD_W(PERIOD_W)) u_cfg (
        .clk       (clk),
        .rst       (rst),
        .cfg_wr_en (cfg_wr_en),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .en        (en),
        .auto_mode (auto_mode),
        .start     (start),
        .clr_err   (clr_err),
        .thresh    (thresh),
        .rounds    (rounds),
        .period    (period)
    );

`ifdef IRST_WDOG_EN
    logic [WDOG_W-1:0] wdog_cnt;

    assign wdog_hit = (state == ST_RUN) && (wdog_cnt == WDOG_LIMIT);
    assign wdog_rel = (state == ST_RELEASE) && (wdog_cnt == WDOG_LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if ((state_n == ST_RUN && state != ST_RUN) ||
                (state == ST_RUN && state_n == ST_RELEASE))
                wdog_cnt <= '0;
            else if (state == ST_RUN || state == ST_RELEASE)
                wdog_cnt <= wdog_cnt + 1'b1;
            if (wdog_hit)
                timeout_err <= 1'b1;
            else if (clr_err)
                timeout_err <= 1'b0;
        end
    end
`else
    logic unused_wdog;
    assign unused_wdog = ^{clr_err, WDOG_LIMIT};
    assign wdog_hit    = 1'b0;
    assign wdog_rel    = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_n   = state;
        per_cnt_n = per_cnt;
        capture   = 1'b0;
        done_inc  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (en && start) begin
                    state_n = ST_DRAIN;
                end else if (en && auto_mode) begin
                    state_n   = ST_WAIT;
                    per_cnt_n = period;
                end
            end
            ST_WAIT: begin
                if (!(en && auto_mode))
                    state_n = ST_IDLE;
                else if (start || per_cnt == '0)
                    state_n = ST_DRAIN;
                else
                    per_cnt_n = per_cnt - 1'b1;
            end
            ST_DRAIN: begin
                if (!en) begin
                    state_n = ST_IDLE;
                end else if (pipe_idle) begin
                    state_n = ST_RUN;
                    capture = 1'b1;
                end
            end
            ST_RUN: begin
                // Aborts and watchdog expiry leave without counting a session.
                if (!en || wdog_hit) begin
                    state_n = ST_RELEASE;
                end else if (irst_done) begin
                    state_n  = ST_RELEASE;
                    done_inc = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (!irst_done || wdog_rel) begin
                    if (en && auto_mode) begin
                        state_n   = ST_WAIT;
                        per_cnt_n = period;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        thr_n = capture ? thresh : thr_sh;
        rnd_n = capture ? rounds : rnd_sh;
        case (state_n)
            ST_RUN:     word_n = make_word(1'b1, thr_n, rnd_n);
            ST_RELEASE: word_n = make_word(1'b0, thr_n, rnd_n);
            default:    word_n = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            per_cnt       <= '0;
            thr_sh        <= '0;
            rnd_sh        <= '0;
            session_cnt   <= '0;
            irst_reg_data <= '0;
            drain_req     <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_n;
            per_cnt       <= per_cnt_n;
            thr_sh        <= thr_n;
            rnd_sh        <= rnd_n;
            irst_reg_data <= word_n;
            drain_req     <= (state_n == ST_DRAIN);
            busy          <= (state_n != ST_IDLE);
            if (done_inc && session_cnt != 8'hFF)
                session_cnt <= session_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_irst_sched.sv
// tb/tb_irst_sched.sv - scoreboard bench for irst_sched against a cycle-timed session model
module tb_irst_sched;
    import irst_sched_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_wr_en;
    logic [1:0]  cfg_addr;
    logic [15:0] cfg_wdata;
    logic        pipe_idle;
    logic        irst_done;
    logic [15:0] irst_reg_data;
    logic        drain_req;
    logic        busy;
    logic [7:0]  session_cnt;
    logic        timeout_err;

    irst_sched dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_wr_en     (cfg_wr_en),
        .cfg_addr      (cfg_addr),
        .cfg_wdata     (cfg_wdata),
        .pipe_idle     (pipe_idle),
        .irst_done     (irst_done),
        .irst_reg_data (irst_reg_data),
        .drain_req     (drain_req),
        .busy          (busy),
        .session_cnt   (session_cnt),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [15:0] word;
        logic        drain;
        logic        busy;
        logic [7:0]  scnt;
    } ev_t;

    ev_t         sb[$];
    int          total = 0;
    int          bad = 0;
    bit          mon_en = 0;
    logic [15:0] pw, ew;
    logic        pd, pb, ed, eb;
    logic [7:0]  ps, es;
    logic [7:0]  scnt;
    logic [6:0]  thr_cfg;
    logic [5:0]  rnd_cfg;

    // Monitor: every change of the observable outputs must match the next expected event.
    always @(negedge clk) begin
        if (mon_en && (irst_reg_data !== pw || drain_req !== pd || busy !== pb ||
                       session_cnt !== ps)) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_change cyc=%0d word=%h drain=%b busy=%b cnt=%0d",
                         cyc, irst_reg_data, drain_req, busy, session_cnt);
            end else begin
                ev_t e;
                e = sb.pop_front();
                if (e.cyc != cyc || e.word !== irst_reg_data || e.drain !== drain_req ||
                    e.busy !== busy || e.scnt !== session_cnt) begin
                    bad++;
                    $display("FAIL event got cyc=%0d word=%h drain=%b busy=%b cnt=%0d want cyc=%0d word=%h drain=%b busy=%b cnt=%0d",
                             cyc, irst_reg_data, drain_req, busy, session_cnt,
                             e.cyc, e.word, e.drain, e.busy, e.scnt);
                end
            end
            pw = irst_reg_data;
            pd = drain_req;
            pb = busy;
            ps = session_cnt;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        cfg_wr_en = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        tick();
        cfg_wr_en = 1'b0;
        cfg_wdata = '0;
    endtask

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    task automatic expect_at(input int c, input logic [15:0] w, input logic d, input logic b);
        if (w !== ew || d !== ed || b !== eb || scnt !== es) begin
            sb.push_back('{c, w, d, b, scnt});
            ew = w;
            ed = d;
            eb = b;
            es = scnt;
        end
    endtask

    function automatic logic [15:0] run_word();
        return {1'b1, thr_cfg, 2'b00, rnd_cfg};
    endfunction

    // Manual session: start written at n, pipe_idle rises at n+d, done after r RUN cycles.
    task automatic session(input int d, input int r, input int h, input bit mid,
                           input bit abort_run, input bit restart);
        int n, m, p, q;
        logic [15:0] w;
        pipe_idle = 1'b0;
        n = cyc;
        expect_at(n + 1, 16'h0, 1'b1, 1'b1);
        wr(IRST_CTRL, 16'h0005);
        if (restart) wr(IRST_CTRL, 16'h0005);
        m = n + d;
        wait_until(m);
        pipe_idle = 1'b1;
        w = run_word();
        expect_at(m + 1, w, 1'b0, 1'b1);
        wait_until(m + 1);
        if (mid) begin
            wr(IRST_THRESH, 16'hFF7F);
            thr_cfg = 7'h7F;
        end
        if (abort_run) begin
            p = cyc;
            expect_at(p + 1, w & 16'h7FFF, 1'b0, 1'b1);
            expect_at(p + 2, 16'h0, 1'b0, 1'b0);
            wr(IRST_CTRL, 16'h0000);
            wait_until(p + 2);
        end else begin
            wait_until(m + 1 + r);
            p = cyc;
            if (scnt != 8'hFF) scnt++;
            expect_at(p + 1, w & 16'h7FFF, 1'b0, 1'b1);
            irst_done = 1'b1;
            wait_until(p + 1 + h);
            q = cyc;
            expect_at(q + 1, 16'h0, 1'b0, 1'b0);
            irst_done = 1'b0;
            wait_until(q + 1);
        end
    endtask

    // Auto mode: WAIT spans PERIOD+1 cycles before each DRAIN.
    task automatic auto_run(input int per, input int nsess);
        int t, m, p, q;
        logic [15:0] w;
        wr(IRST_PERIOD, per[15:0]);
        pipe_idle = 1'b1;
        t = cyc + 1;
        expect_at(t, 16'h0, 1'b0, 1'b1);
        wr(IRST_CTRL, 16'h0003);
        for (int k = 0; k < nsess; k++) begin
            m = t + per + 1;
            expect_at(m, 16'h0, 1'b1, 1'b1);
            w = run_word();
            expect_at(m + 1, w, 1'b0, 1'b1);
            wait_until(m + 1 + int'($urandom_range(0, 3)));
            p = cyc;
            if (scnt != 8'hFF) scnt++;
            expect_at(p + 1, w & 16'h7FFF, 1'b0, 1'b1);
            irst_done = 1'b1;
            wait_until(p + 1 + int'($urandom_range(0, 2)));
            q = cyc;
            expect_at(q + 1, 16'h0, 1'b0, 1'b1);
            irst_done = 1'b0;
            t = q + 1;
        end
        wait_until(t);
        expect_at(t + 1, 16'h0, 1'b0, 1'b0);
        wr(IRST_CTRL, 16'h0000);
        wait_until(t + 2);
    endtask

    initial begin
        logic [15:0] td;
        int n, x;
        rst = 1'b1;
        cfg_wr_en = 1'b0;
        cfg_addr = '0;
        cfg_wdata = '0;
        pipe_idle = 1'b0;
        irst_done = 1'b0;
        scnt = '0;
        thr_cfg = '0;
        rnd_cfg = '0;
        ew = '0; ed = 1'b0; eb = 1'b0; es = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("reset_word", irst_reg_data, 16'h0);
        chk("reset_drain", {15'h0, drain_req}, 16'h0);
        chk("reset_busy", {15'h0, busy}, 16'h0);
        chk("reset_cnt", {8'h0, session_cnt}, 16'h0);
        chk("reset_err", {15'h0, timeout_err}, 16'h0);
        pw = irst_reg_data; pd = drain_req; pb = busy; ps = session_cnt;
        mon_en = 1'b1;

        wr(IRST_THRESH, 16'h0020); thr_cfg = 7'h20;
        wr(IRST_ROUNDS, 16'h0003); rnd_cfg = 6'h03;
        session(1, 3, 2, 1'b0, 1'b0, 1'b0);
        chk("basic_cnt", {8'h0, session_cnt}, 16'h1);
        session(51, 2, 1, 1'b0, 1'b0, 1'b0);
        session(3, 1, 1, 1'b1, 1'b0, 1'b0);
        session(2, 0, 0, 1'b0, 1'b0, 1'b0);
        session(2, 2, 0, 1'b0, 1'b1, 1'b0);
        session(3, 1, 0, 1'b0, 1'b0, 1'b1);
        wr(IRST_ROUNDS, 16'hFFC0); rnd_cfg = 6'h00;
        auto_run(10, 2);
        auto_run(0, 3);
        auto_run(int'($urandom_range(1, 20)), 2);

        for (int i = 0; i < 300; i++) begin
            bit rs, ab;
            int d;
            if ($urandom_range(0, 1) == 1) begin
                td = 16'($urandom);
                wr(IRST_THRESH, td);
                thr_cfg = td[6:0];
            end
            if ($urandom_range(0, 1) == 1) begin
                td = 16'($urandom);
                wr(IRST_ROUNDS, td);
                rnd_cfg = td[5:0];
            end
            rs = ($urandom_range(0, 5) == 0);
            ab = ($urandom_range(0, 9) == 0);
            d = int'($urandom_range(rs ? 2 : 1, 4));
            session(d, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'b0, ab, rs);
        end
        chk("cnt_saturated", {8'h0, session_cnt}, {8'h0, scnt});

`ifdef IRST_WDOG_EN
        pipe_idle = 1'b1;
        n = cyc;
        expect_at(n + 1, 16'h0, 1'b1, 1'b1);
        wr(IRST_CTRL, 16'h0005);
        expect_at(n + 2, run_word(), 1'b0, 1'b1);
        expect_at(n + 3 + 4095, run_word() & 16'h7FFF, 1'b0, 1'b1);
        expect_at(n + 4 + 4095, 16'h0, 1'b0, 1'b0);
        wait_until(n + 5 + 4095);
        chk("wdog_err_set", {15'h0, timeout_err}, 16'h1);
        wr(IRST_CTRL, 16'h0008);
        chk("wdog_err_clr", {15'h0, timeout_err}, 16'h0);
`endif

        pipe_idle = 1'b1;
        n = cyc;
        expect_at(n + 1, 16'h0, 1'b1, 1'b1);
        wr(IRST_CTRL, 16'h0005);
        expect_at(n + 2, run_word(), 1'b0, 1'b1);
        wait_until(n + 3);
        x = cyc;
        scnt = '0;
        expect_at(x + 1, 16'h0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        thr_cfg = '0;
        rnd_cfg = '0;
        repeat (3) tick();
        chk("post_rst_err", {15'h0, timeout_err}, 16'h0);

        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL missing_events got=%0d pending want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
